mealy_serial_ctrl: RTL and testbench

//  Sequencer that owns the serial Mealy sequence detector (fsm_mealy: clk, reset, en, xin, zout).

---
 rtl/mealy_ctrl_pkg.sv | 13 +
 rtl/mealy_serial_ctrl.sv | 114 +++++++++++
 tb/tb_mealy_serial_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/mealy_ctrl_pkg.sv
// Shared types for the serial Mealy detector sequencer.
package mealy_ctrl_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_SHIFT = 2'b10,
        ST_HOLD  = 2'b11
    } ctrl_state_t;

endpackage

// File: rtl/mealy_serial_ctrl.sv
// Accepts parallel words, shifts them MSB-first into an external Mealy
// detector, and returns the per-bit match mask and match count.
module mealy_serial_ctrl
    import mealy_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_restart,
    input  logic             stall,
    output logic             det_en,
    output logic             det_xin,
    output logic             det_clr,
    input  logic             det_zout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_mask,
    output logic [CNT_W-1:0] out_count,
    output logic             busy
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] word_q,  word_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            word_q  <= {WIDTH{1'b0}};
            mask_q  <= {WIDTH{1'b0}};
            count_q <= {CNT_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    // Next-state and detector/handshake outputs; det_en follows stall combinationally.
    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        mask_d    = mask_q;
        count_d   = count_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        det_en    = 1'b0;
        det_xin   = 1'b0;
        det_clr   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    mask_d  = {WIDTH{1'b0}};
                    count_d = {CNT_W{1'b0}};
                    idx_d   = IDX_W'(WIDTH - 1);
                    state_d = in_restart ? ST_CLEAR : ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                det_clr = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                det_xin = word_q[idx_q];
                det_en  = ~stall;
                if (!stall) begin
                    mask_d[idx_q] = det_zout;
                    count_d       = count_q + {{(CNT_W-1){1'b0}}, det_zout};
                    if (idx_q == {IDX_W{1'b0}}) begin
                        state_d = ST_HOLD;
                    end else begin
                        idx_d = idx_q - {{(IDX_W-1){1'b0}}, 1'b1};
                    end
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_mask  = mask_q;
    assign out_count = count_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mealy_serial_ctrl.sv
// Scoreboard bench for mealy_serial_ctrl with a stub detector:
// zout = en & xin & prev, prev tracks xin while en and clears on det_clr.
module tb_mealy_serial_ctrl;

    typedef struct packed {
        logic [7:0] mask;
        logic [3:0] count;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_restart = 1'b0;
    logic       stall = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, det_en, det_xin, det_clr, det_zout, out_valid, busy;
    logic [7:0] out_mask;
    logic [3:0] out_count;
    logic       prev_q;

    int   checks = 0;
    int   failures = 0;
    logic model_prev = 1'b0;
    exp_t sb_q[$];

    mealy_serial_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_restart(in_restart), .stall(stall),
        .det_en(det_en), .det_xin(det_xin), .det_clr(det_clr), .det_zout(det_zout),
        .out_valid(out_valid), .out_ready(out_ready), .out_mask(out_mask),
        .out_count(out_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Stub detector: flags a 1 that follows a 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev_q <= 1'b0;
        else if (det_clr) prev_q <= 1'b0;
        else if (det_en) prev_q <= det_xin;
        else prev_q <= prev_q;
    end
    assign det_zout = det_en & det_xin & prev_q;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_expected(input logic [7:0] data, input logic restart);
        exp_t e;
        logic z;
        e = '0;
        if (restart) model_prev = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            z          = data[i] & model_prev;
            e.mask[i]  = z;
            e.count    = e.count + {3'b000, z};
            model_prev = data[i];
        end
        sb_q.push_back(e);
    endtask

    task automatic run_word(input logic [7:0] data, input logic restart,
                            input int stall_after, input int stall_len, input int hold_len);
        int lat, bits, clrs, stall_left;
        logic [7:0] xin_seq;
        exp_t e;
        @(negedge clk);
        check_val("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_data = data; in_restart = restart;
        push_expected(data, restart);
        @(negedge clk);
        in_valid = 1'b0; in_restart = 1'b0;
        lat = 1; bits = 0; clrs = 0; stall_left = stall_len; xin_seq = 8'h00;
        while (!out_valid && lat < 40) begin
            stall = (bits == stall_after) && (stall_left > 0);
            #1;
            check_val("in_ready_busy", in_ready, 0);
            if (stall) begin
                check_val("det_en_stall", det_en, 0);
                stall_left--;
            end
            if (det_clr) clrs++;
            if (det_en) begin
                xin_seq = {xin_seq[6:0], det_xin};
                bits++;
            end
            @(negedge clk);
            lat++;
        end
        stall = 1'b0;
        check_val("out_valid_timeout", out_valid, 1);
        if (!out_valid) return;
        check_val("latency", lat, 9 + int'(restart) + stall_len);
        check_val("det_en_cycles", bits, 8);
        check_val("det_clr_cycles", clrs, int'(restart));
        check_val("xin_sequence", xin_seq, data);
        check_val("sb_nonempty", sb_q.size() > 0, 1);
        if (sb_q.size() == 0) return;
        e = sb_q.pop_front();
        check_val("out_mask", out_mask, e.mask);
        check_val("out_count", out_count, e.count);
        for (int h = 0; h < hold_len; h++) begin
            @(negedge clk);
            check_val("hold_valid", out_valid, 1);
            check_val("hold_mask", out_mask, e.mask);
            check_val("hold_count", out_count, e.count);
            check_val("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check_val("idle_busy", busy, 0);
        check_val("idle_in_ready", in_ready, 1);
        check_val("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int bits, guard;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst_in_ready", in_ready, 1);
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_det_en", det_en, 0);
        check_val("rst_det_xin", det_xin, 0);
        check_val("rst_det_clr", det_clr, 0);
        check_val("rst_mask", out_mask, 0);
        check_val("rst_count", out_count, 0);
        reset = 1'b1;
        model_prev = 1'b0;

        run_word(8'h6E, 1'b1, 99, 0, 0);
        run_word(8'h6E, 1'b1, 3, 2, 0);
        run_word(8'h01, 1'b1, 99, 0, 0);
        run_word(8'h80, 1'b0, 99, 0, 0);
        run_word(8'h01, 1'b1, 99, 0, 0);
        run_word(8'h80, 1'b1, 99, 0, 0);
        run_word(8'hB7, 1'b0, 99, 0, 5);

        // Reset in the 4th shift cycle of a word.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF; in_restart = 1'b0;
        push_expected(8'hFF, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        bits = 0; guard = 0;
        while (bits < 3 && guard < 20) begin
            #1;
            if (det_en) bits++;
            @(negedge clk);
            guard++;
        end
        check_val("midword_reach", bits, 3);
        reset = 1'b0;
        #1;
        check_val("mrst_in_ready", in_ready, 1);
        check_val("mrst_out_valid", out_valid, 0);
        check_val("mrst_det_en", det_en, 0);
        check_val("mrst_busy", busy, 0);
        void'(sb_q.pop_back());
        model_prev = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        run_word(8'h6E, 1'b0, 99, 0, 0);

        for (int k = 0; k < 6; k++) begin
            run_word(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
